latch_word_capture: RTL and testbench

LATCH_WORD_CAPTURE -- requirements
Module: latch_word_capture

---
 rtl/latch_word_capture.sv | 180 ++++++++++++++++++
 tb/tb_latch_word_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/latch_word_capture.sv
// -----------------------------------------------------------------------------
// latch_word_capture
//
// Serially captures one WIDTH-bit word from an upstream D latch (MSB first)
// and presents it to a downstream consumer through a valid/ready handshake.
// While a capture is running, the latch's complementary outputs are
// cross-checked. If Q ever equals Qn, a sticky complement error is flagged.
//
// Optional feature (compile-time macro LATCH_WORD_CAPTURE_PARITY_EN):
//   One extra even-parity bit is sampled after the data bits. err_parity
//   reports whether the parity check failed. When the macro is undefined,
//   the PAR state is never entered and err_parity is tied to 0.
//
// Parameters
//   WIDTH       data bits per word (2..32)
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset
//   start       request to begin capturing a word (honoured only in IDLE)
//   q_in        latch output Q (the sampled data bit)
//   qn_in       latch output Qn (complement cross-check)
//   word_ready  consumer accepts the word (honoured only in HOLD)
//   word        captured word; stable while word_valid is high
//   word_valid  captured word available (state HOLD)
//   busy        capture in progress (states SHIFT and PAR)
//   err_comp    sticky: q_in == qn_in seen during the capture
//   err_parity  parity check failed (parity build only)
// -----------------------------------------------------------------------------
module latch_word_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q_in,
  input  logic             qn_in,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             err_comp,
  output logic             err_parity
);

  // One extra bit so that the counter can represent WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               err_comp_q, err_comp_d;

  logic last_bit;
  logic comp_bad;

  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign comp_bad = (q_in == qn_in);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef LATCH_WORD_CAPTURE_PARITY_EN
          state_d = PAR;
`else
          state_d = HOLD;
`endif
        end
      end
      PAR:   state_d = HOLD;
      HOLD:  if (word_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (pure function of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    word_valid = 1'b0;
    case (state_q)
      SHIFT, PAR: busy       = 1'b1;
      HOLD:       word_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, complement error
  // ---------------------------------------------------------------------------
  always_comb begin
    word_d     = word_q;
    bit_cnt_d  = bit_cnt_q;
    err_comp_d = err_comp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bit_cnt_d  = '0;
          err_comp_d = 1'b0;
        end
      end
      SHIFT: begin
        // The bit is always taken from Q, even when Q/Qn disagree.
        word_d    = {word_q[WIDTH-2:0], q_in};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (comp_bad) err_comp_d = 1'b1;
      end
      PAR: begin
        if (comp_bad) err_comp_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      bit_cnt_q  <= '0;
      err_comp_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      bit_cnt_q  <= bit_cnt_d;
      err_comp_q <= err_comp_d;
    end
  end

  assign word     = word_q;
  assign err_comp = err_comp_q;

  // ---------------------------------------------------------------------------
  // Parity check
  // ---------------------------------------------------------------------------
`ifdef LATCH_WORD_CAPTURE_PARITY_EN
  logic err_parity_q, err_parity_d;

  always_comb begin
    err_parity_d = err_parity_q;
    if (state_q == IDLE && start) begin
      err_parity_d = 1'b0;
    end else if (state_q == PAR) begin
      // Even parity: the data bits and the parity bit must XOR to zero.
      // The flag is updated on the edge that enters HOLD.
      err_parity_d = (^word_q) ^ q_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_parity_q <= 1'b0;
    end else begin
      err_parity_q <= err_parity_d;
    end
  end

  assign err_parity = err_parity_q;
`else
  assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_latch_word_capture.sv
// -----------------------------------------------------------------------------
// tb_latch_word_capture
//
// Scoreboard bench for latch_word_capture (WIDTH = 8). Each capture pushes its
// expected word and error flags when the stimulus is driven. The entry is
// popped and compared when the DUT raises word_valid. It works in either
// build: LATCH_WORD_CAPTURE_PARITY_EN defined or undefined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_latch_word_capture;

`ifdef LATCH_WORD_CAPTURE_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             q_in;
  logic             qn_in;
  logic             word_ready;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             busy;
  logic             err_comp;
  logic             err_parity;

  latch_word_capture #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .q_in       (q_in),
    .qn_in      (qn_in),
    .word_ready (word_ready),
    .word       (word),
    .word_valid (word_valid),
    .busy       (busy),
    .err_comp   (err_comp),
    .err_parity (err_parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             comp;
    logic             par;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete capture and handshake.
  //   bad_idx    sample index (0 = first) at which q_in == qn_in, or -1
  //   par_bit    parity bit driven in the parity build
  //   hold_cyc   cycles word_ready is held low in HOLD
  //   keep_start leave start asserted through the whole capture and handshake
  task automatic capture(input logic [WIDTH-1:0] data, input int bad_idx,
                         input logic par_bit, input int hold_cyc, input bit keep_start);
    exp_t e;
    e.word = data;
    e.comp = (bad_idx >= 0 && bad_idx < WIDTH);
    e.par  = PAR_ON ? ((^data) ^ par_bit) : 1'b0;
    sb.push_back(e);

    start = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_valid", word_valid, 0);
    chk("start_comp_clr", err_comp, 0);
    chk("start_par_clr", err_parity, 0);
    if (!keep_start) start = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      q_in       = data[WIDTH-1-i];
      qn_in      = (i == bad_idx) ? q_in : ~q_in;
      word_ready = 1'($urandom_range(0, 1));   // must be ignored outside HOLD
      tick();
      if (i < WIDTH - 1 || PAR_ON) begin
        chk("shift_valid", word_valid, 0);
        chk("shift_busy", busy, 1);
      end
    end
    if (PAR_ON) begin
      q_in  = par_bit;
      qn_in = ~par_bit;
      tick();
    end
    word_ready = 1'b0;
    q_in       = 1'b0;
    qn_in      = 1'b1;

    chk("lat_valid", word_valid, 1);
    chk("lat_busy", busy, 0);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("word", word, e.word);
      chk("err_comp", err_comp, e.comp);
      chk("err_parity", err_parity, e.par);
    end

    for (int h = 0; h < hold_cyc; h++) begin
      q_in  = 1'($urandom_range(0, 1));
      qn_in = q_in;                         // disagreement outside capture is ignored
      tick();
      chk("hold_word", word, e.word);
      chk("hold_valid", word_valid, 1);
      chk("hold_comp", err_comp, e.comp);
    end

    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    q_in       = 1'b0;
    qn_in      = 1'b1;
    chk("done_valid", word_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_word", word, e.word);
    $display("capture data=0x%02h bad=%0d par_bit=%0d hold=%0d keep_start=%0d",
             data, bad_idx, par_bit, hold_cyc, keep_start);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    q_in       = 1'b0;
    qn_in      = 1'b1;
    word_ready = 1'b0;
    tick();
    tick();
    chk("rst_word", word, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_comp", err_comp, 0);
    chk("rst_par", err_parity, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Basic word with a long stall in HOLD.
    capture(8'hB2, -1, 1'b0, 5, 1'b0);
    // Complement error at the third sample; the next capture's start clears it.
    capture(8'hB2, 2, 1'b0, 1, 1'b0);

    // Reset after the fourth sample discards the partial word.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_in  = 1'b1;
      qn_in = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_word", word, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", word_valid, 0);
    $display("reset mid-capture after 4 samples");
    capture(8'h5C, -1, 1'b1, 0, 1'b0);

    // start held high through SHIFT, HOLD and the handshake edge.
    capture(8'hA7, -1, 1'b0, 2, 1'b1);
    capture(8'h3C, -1, 1'b0, 0, 1'b0);

    // Parity cases (err_parity stays 0 in the plain build).
    capture(8'hB2, -1, 1'b1, 0, 1'b0);
    capture(8'hB2, -1, 1'b0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      capture(8'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
